// File: rtl/store_result.sv
// ---------------------------------------------------------------------------
// store_result
//   Drains I_len words from the result RAM and writes them to DDR at
//   I_base_addr over an AXI write master (AW/W/B). The job is split into
//   bursts of at most C_MAX_BURST beats, with one burst outstanding at a time.
//   Sits between the main-process output buffer and the AXI interconnect.
//
//   RAM words are read ahead into a 2-entry skid FIFO so that W can stream
//   at one beat per cycle while absorbing wready stalls without overflow.
//
// Ports
//   I_clk, I_rst          clock, synchronous active-high reset
//   I_ap_start/O_ap_done  level start (rising edge launches a job) / done
//   I_base_addr, I_len    DDR byte address of word 0, number of words
//   O_braddr/O_brd        RAM read address / enable (data 1 cycle later)
//   I_brdata              RAM read data
//   O_maxi_aw*, _w*, _b*  AXI write address, data and response channels
//   O_err                 sticky bad-response flag
//
// Build option
//   STORE_BRESP_CHECK_EN  when defined, a non-OKAY bresp sets O_err (sticky
//                         until reset or the next start edge); otherwise
//                         I_maxi_bresp is ignored and O_err is tied low.
// ---------------------------------------------------------------------------
module store_result #(
  parameter int C_M_AXI_LEN_WIDTH  = 32,
  parameter int C_M_AXI_ADDR_WIDTH = 32,
  parameter int C_M_AXI_DATA_WIDTH = 128,
  parameter int C_RAM_ADDR_WIDTH   = 10,
  parameter int C_RAM_DATA_WIDTH   = 128,
  parameter int C_MAX_BURST        = 16
) (
  input  logic                          I_clk,
  input  logic                          I_rst,
  input  logic                          I_ap_start,
  output logic                          O_ap_done,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0] I_base_addr,
  input  logic [C_RAM_ADDR_WIDTH-1:0]   I_len,
  output logic [C_RAM_ADDR_WIDTH-1:0]   O_braddr,
  output logic                          O_brd,
  input  logic [C_RAM_DATA_WIDTH-1:0]   I_brdata,
  output logic                          O_maxi_awvalid,
  input  logic                          I_maxi_awready,
  output logic [C_M_AXI_ADDR_WIDTH-1:0] O_maxi_awaddr,
  output logic [C_M_AXI_LEN_WIDTH-1:0]  O_maxi_awlen,
  output logic                          O_maxi_wvalid,
  input  logic                          I_maxi_wready,
  output logic [C_M_AXI_DATA_WIDTH-1:0] O_maxi_wdata,
  output logic                          O_maxi_wlast,
  input  logic                          I_maxi_bvalid,
  output logic                          O_maxi_bready,
  input  logic [1:0]                    I_maxi_bresp,
  output logic                          O_err
);

  localparam int BYTES = C_M_AXI_DATA_WIDTH / 8;
  localparam int BW    = $clog2(C_MAX_BURST + 1);

  typedef enum logic [2:0] {S_IDLE, S_AW, S_W, S_B, S_DONE} state_t;

  state_t                          state;
  logic                            start_d;
  logic                            start_edge;
  logic [C_M_AXI_ADDR_WIDTH-1:0]   cur_addr;
  logic [C_RAM_ADDR_WIDTH-1:0]     remaining;   // words not yet assigned to a burst
  logic [C_RAM_ADDR_WIDTH-1:0]     rd_addr;
  logic [BW-1:0]                   burst_len;   // beats in the current burst
  logic [BW-1:0]                   rd_left;     // RAM reads still to issue for this burst
  logic [BW-1:0]                   w_left;      // W beats still to send for this burst
  logic                            awvalid_r;
  logic                            bready_r;
  logic                            done_r;

  // Skid FIFO between the RAM and the W channel
  logic [C_RAM_DATA_WIDTH-1:0]     fifo_mem [2];
  logic                            wr_ptr;
  logic                            rd_ptr;
  logic [1:0]                      fifo_cnt;
  logic                            rd_pend;     // a RAM read issued last cycle
  logic [2:0]                      occ_eff;
  logic                            wvalid;
  logic                            w_fire;
  logic                            brd;

  function automatic logic [BW-1:0] burst_of(input logic [C_RAM_ADDR_WIDTH-1:0] n);
    if (32'(n) > 32'(C_MAX_BURST)) burst_of = BW'(C_MAX_BURST);
    else                           burst_of = BW'(n);
  endfunction

  assign start_edge = I_ap_start & ~start_d;
  assign wvalid     = (state == S_W) && (fifo_cnt != 2'd0);
  assign w_fire     = wvalid & I_maxi_wready;

  // Read-ahead: occupancy counts the entry leaving this cycle as already
  // gone, which is what lets the pipeline sustain one beat per cycle.
  always_comb begin
    // NOTE: every variable written here gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    occ_eff = 3'(fifo_cnt) + 3'(rd_pend) - 3'(w_fire);
    brd     = 1'b0;
    if ((state == S_AW || state == S_W) && rd_left != '0 && occ_eff < 3'd2)
      brd = 1'b1;
  end

  // NOTE: the FIFO storage is not reset; it is only observable through
  // O_maxi_wdata, which is forced to zero whenever the FIFO is empty.
  always_ff @(posedge I_clk) begin
    if (rd_pend) fifo_mem[wr_ptr] <= I_brdata;
  end

  always_ff @(posedge I_clk) begin
    if (I_rst) begin
      rd_pend  <= 1'b0;
      wr_ptr   <= 1'b0;
      rd_ptr   <= 1'b0;
      fifo_cnt <= 2'd0;
    end else begin
      rd_pend  <= brd;
      if (rd_pend) wr_ptr <= ~wr_ptr;
      if (w_fire)  rd_ptr <= ~rd_ptr;
      fifo_cnt <= fifo_cnt + 2'(rd_pend) - 2'(w_fire);
    end
  end

  // Job control FSM
  always_ff @(posedge I_clk) begin
    // NOTE: sequential state uses non-blocking assignments only, so every
    // right-hand side here sees the values from before this clock edge.
    if (I_rst) begin
      state     <= S_IDLE;
      start_d   <= 1'b0;
      cur_addr  <= '0;
      remaining <= '0;
      rd_addr   <= '0;
      burst_len <= '0;
      rd_left   <= '0;
      w_left    <= '0;
      awvalid_r <= 1'b0;
      bready_r  <= 1'b0;
      done_r    <= 1'b0;
    end else begin
      start_d <= I_ap_start;

      if (brd) begin
        rd_addr <= rd_addr + C_RAM_ADDR_WIDTH'(1);
        rd_left <= rd_left - BW'(1);
      end

      unique case (state)
        S_IDLE: begin
          if (start_edge) begin
            cur_addr  <= I_base_addr;
            remaining <= I_len;
            rd_addr   <= '0;
            if (I_len == '0) begin
              state  <= S_DONE;
              done_r <= 1'b1;
            end else begin
              state     <= S_AW;
              awvalid_r <= 1'b1;
              burst_len <= burst_of(I_len);
              rd_left   <= burst_of(I_len);
              w_left    <= burst_of(I_len);
            end
          end
        end

        S_AW: begin
          if (I_maxi_awready) begin
            awvalid_r <= 1'b0;
            remaining <= remaining - C_RAM_ADDR_WIDTH'(burst_len);
            state     <= S_W;
          end
        end

        S_W: begin
          if (w_fire) begin
            w_left <= w_left - BW'(1);
            if (w_left == BW'(1)) begin
              state    <= S_B;
              bready_r <= 1'b1;
            end
          end
        end

        S_B: begin
          if (bready_r && I_maxi_bvalid) begin
            bready_r <= 1'b0;
            if (remaining == '0) begin
              state  <= S_DONE;
              done_r <= 1'b1;
            end else begin
              // Byte address wraps naturally at the address width
              cur_addr  <= cur_addr + C_M_AXI_ADDR_WIDTH'(burst_len) * C_M_AXI_ADDR_WIDTH'(BYTES);
              state     <= S_AW;
              awvalid_r <= 1'b1;
              burst_len <= burst_of(remaining);
              rd_left   <= burst_of(remaining);
              w_left    <= burst_of(remaining);
            end
          end
        end

        S_DONE: begin
          if (!I_ap_start) begin
            state  <= S_IDLE;
            done_r <= 1'b0;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef STORE_BRESP_CHECK_EN
  logic err_r;

  always_ff @(posedge I_clk) begin
    if (I_rst)
      err_r <= 1'b0;
    else if (state == S_IDLE && start_edge)
      err_r <= 1'b0;
    else if (state == S_B && bready_r && I_maxi_bvalid && I_maxi_bresp != 2'b00)
      err_r <= 1'b1;
  end

  assign O_err = err_r;
`else
  logic unused_bresp;
  assign unused_bresp = ^I_maxi_bresp;
  assign O_err        = 1'b0;
`endif

  assign O_ap_done      = done_r;
  assign O_braddr       = rd_addr;
  assign O_brd          = brd;
  assign O_maxi_awvalid = awvalid_r;
  assign O_maxi_awaddr  = cur_addr;
  assign O_maxi_awlen   = C_M_AXI_LEN_WIDTH'(burst_len);
  assign O_maxi_wvalid  = wvalid;
  assign O_maxi_wdata   = wvalid ? fifo_mem[rd_ptr] : '0;
  assign O_maxi_wlast   = wvalid && (w_left == BW'(1));
  assign O_maxi_bready  = bready_r;

endmodule

// File: tb/tb_store_result.sv
// ---------------------------------------------------------------------------
// tb_store_result
//   Self-checking bench for store_result. A RAM model feeds the read port;
//   an AXI slave process with configurable AW delay, random wready and
//   delayed B responses checks every handshake against a reference built
//   from the job description (burst list and RAM contents).
// ---------------------------------------------------------------------------
module tb_store_result;

  logic         I_clk;
  logic         I_rst;
  logic         I_ap_start;
  logic         O_ap_done;
  logic [31:0]  I_base_addr;
  logic [9:0]   I_len;
  logic [9:0]   O_braddr;
  logic         O_brd;
  logic [127:0] I_brdata;
  logic         O_maxi_awvalid;
  logic         I_maxi_awready;
  logic [31:0]  O_maxi_awaddr;
  logic [31:0]  O_maxi_awlen;
  logic         O_maxi_wvalid;
  logic         I_maxi_wready;
  logic [127:0] O_maxi_wdata;
  logic         O_maxi_wlast;
  logic         I_maxi_bvalid;
  logic         O_maxi_bready;
  logic [1:0]   I_maxi_bresp;
  logic         O_err;

  logic [127:0] ram [0:1023];
  int           n_checks = 0;
  int           n_fail   = 0;

  store_result dut (
    .I_clk          (I_clk),
    .I_rst          (I_rst),
    .I_ap_start     (I_ap_start),
    .O_ap_done      (O_ap_done),
    .I_base_addr    (I_base_addr),
    .I_len          (I_len),
    .O_braddr       (O_braddr),
    .O_brd          (O_brd),
    .I_brdata       (I_brdata),
    .O_maxi_awvalid (O_maxi_awvalid),
    .I_maxi_awready (I_maxi_awready),
    .O_maxi_awaddr  (O_maxi_awaddr),
    .O_maxi_awlen   (O_maxi_awlen),
    .O_maxi_wvalid  (O_maxi_wvalid),
    .I_maxi_wready  (I_maxi_wready),
    .O_maxi_wdata   (O_maxi_wdata),
    .O_maxi_wlast   (O_maxi_wlast),
    .I_maxi_bvalid  (I_maxi_bvalid),
    .O_maxi_bready  (O_maxi_bready),
    .I_maxi_bresp   (I_maxi_bresp),
    .O_err          (O_err)
  );

  initial I_clk = 1'b0;
  always #5 I_clk = ~I_clk;

  // Result RAM: 1-cycle read latency
  always @(posedge I_clk) begin
    if (O_brd) I_brdata <= ram[O_braddr];
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One job against a slave with the given behaviour. Reference: the burst
  // list is derived from base/len, the beat stream is ram[0..len-1].
  task automatic run_job(input logic [31:0] base, input int len, input int aw_delay,
                         input int wready_pct, input int b_delay,
                         input bit bad_first, input bit drop_start);
    logic [31:0]  exp_addr[$];
    int           exp_len[$];
    int           left, k, bl;
    int           aw_cnt = 0, wb_cnt = 0, b_cnt = 0, beat = 0, in_burst = 0;
    int           aw_wait = 0, b_wait = 0;
    bit           pend_b = 0, aw_stall = 0, w_stall = 0, done_seen = 0, err_exp = 0;
    bit           last_exp;
    logic [31:0]  sv_awaddr, sv_awlen;
    logic [127:0] sv_wdata;
    logic         sv_wlast;

    left = len;
    k    = 0;
    while (left > 0) begin
      bl = (left > 16) ? 16 : left;
      exp_addr.push_back(base + 32'(k * 16));
      exp_len.push_back(bl);
      k    += bl;
      left -= bl;
    end

    @(negedge I_clk);
    I_base_addr    = base;
    I_len          = 10'(len);
    I_ap_start     = 1'b1;
    I_maxi_awready = 1'b0;
    I_maxi_wready  = 1'b0;
    I_maxi_bvalid  = 1'b0;
    I_maxi_bresp   = 2'b00;

    for (int cyc = 0; cyc < 3000 && !done_seen; cyc++) begin
      @(negedge I_clk);
      if (aw_stall)
        check("aw_hold", {O_maxi_awvalid, O_maxi_awaddr, O_maxi_awlen}, {1'b1, sv_awaddr, sv_awlen});
      if (w_stall) begin
        check("w_hold_data", O_maxi_wdata, sv_wdata);
        check("w_hold_ctl", {O_maxi_wvalid, O_maxi_wlast}, {1'b1, sv_wlast});
      end
      aw_stall = 0;
      w_stall  = 0;

      if (O_ap_done) begin
        done_seen = 1;
        if (len == 0) check("empty_done_latency", cyc < 2, 1'b1);
        I_maxi_awready = 1'b0;
        I_maxi_wready  = 1'b0;
        I_maxi_bvalid  = 1'b0;
      end else begin
        // B channel
        if (pend_b) begin
          if (b_wait >= b_delay) begin
            I_maxi_bvalid = 1'b1;
            I_maxi_bresp  = (bad_first && b_cnt == 0) ? 2'b10 : 2'b00;
            if (O_maxi_bready) begin
              b_cnt++;
              pend_b = 0;
              if (I_maxi_bresp != 2'b00) err_exp = 1;
            end
          end else begin
            I_maxi_bvalid = 1'b0;
            b_wait++;
          end
        end else begin
          check("bready_idle", O_maxi_bready, 1'b0);
          // Spurious error response that must be ignored outside B
          I_maxi_bvalid = ($urandom_range(3) == 0);
          I_maxi_bresp  = 2'b11;
        end

        // W channel
        I_maxi_wready = ($urandom_range(99) < wready_pct);
        if (wready_pct == 100 && in_burst > 0) check("full_rate", O_maxi_wvalid, 1'b1);
        if (O_maxi_wvalid) begin
          check("w_after_aw", aw_cnt > wb_cnt, 1'b1);
          if (I_maxi_wready) begin
            check("w_beats_bound", beat < len && wb_cnt < exp_len.size(), 1'b1);
            if (beat < len && wb_cnt < exp_len.size()) begin
              last_exp = (in_burst == exp_len[wb_cnt] - 1);
              check("wdata", O_maxi_wdata, ram[beat]);
              check("wlast", O_maxi_wlast, last_exp);
              beat++;
              in_burst++;
              if (last_exp) begin
                in_burst = 0;
                wb_cnt++;
                pend_b = 1;
                b_wait = 0;
              end
            end
          end else begin
            w_stall  = 1;
            sv_wdata = O_maxi_wdata;
            sv_wlast = O_maxi_wlast;
          end
        end

        // AW channel
        if (O_maxi_awvalid) begin
          if (aw_wait < aw_delay) begin
            I_maxi_awready = 1'b0;
            aw_wait++;
            aw_stall  = 1;
            sv_awaddr = O_maxi_awaddr;
            sv_awlen  = O_maxi_awlen;
          end else begin
            I_maxi_awready = 1'b1;
            aw_wait = 0;
            check("aw_count_bound", aw_cnt < exp_addr.size(), 1'b1);
            if (aw_cnt < exp_addr.size()) begin
              check("awaddr", O_maxi_awaddr, exp_addr[aw_cnt]);
              check("awlen", O_maxi_awlen, exp_len[aw_cnt]);
            end
            aw_cnt++;
            if (drop_start) I_ap_start = 1'b0;
          end
        end else begin
          I_maxi_awready = 1'b0;
        end
      end
    end

    check("done_seen", done_seen, 1'b1);
    check("beats", beat, len);
    check("aw_bursts", aw_cnt, exp_addr.size());
    check("b_resps", b_cnt, exp_addr.size());
`ifdef STORE_BRESP_CHECK_EN
    check("err_flag", O_err, err_exp);
`else
    check("err_flag", O_err, 1'b0);
`endif
    I_ap_start     = 1'b0;
    I_maxi_awready = 1'b0;
    I_maxi_wready  = 1'b0;
    I_maxi_bvalid  = 1'b0;
    I_maxi_bresp   = 2'b00;
    @(negedge I_clk);
    check("done_clear", O_ap_done, 1'b0);
  endtask

  initial begin
    int n;

    for (int i = 0; i < 1024; i++) ram[i] = {$urandom, $urandom, $urandom, $urandom};

    I_rst          = 1'b1;
    I_ap_start     = 1'b0;
    I_base_addr    = '0;
    I_len          = '0;
    I_maxi_awready = 1'b0;
    I_maxi_wready  = 1'b0;
    I_maxi_bvalid  = 1'b0;
    I_maxi_bresp   = 2'b00;
    repeat (3) @(negedge I_clk);
    check("reset_ctl", {O_maxi_awvalid, O_maxi_wvalid, O_maxi_wlast, O_maxi_bready,
                        O_brd, O_ap_done, O_err}, 7'd0);
    check("reset_addr", {O_maxi_awaddr, O_maxi_awlen, O_braddr}, 74'd0);
    I_rst = 1'b0;

    // Empty job, then the directed scenarios
    run_job(32'h0000_0000, 0, 0, 100, 0, 1'b0, 1'b0);
    run_job(32'h0000_1000, 40, 0, 100, 0, 1'b0, 1'b0);
    run_job(32'h0000_2000, 5, 3, 50, 0, 1'b0, 1'b0);
    run_job(32'h0000_4000, 32, 0, 100, 0, 1'b1, 1'b0);
    run_job(32'h0000_3000, 16, 0, 100, 10, 1'b0, 1'b0);

    // Reset in the middle of a 16-beat burst
    @(negedge I_clk);
    I_base_addr = 32'h0000_5000;
    I_len       = 10'd16;
    I_ap_start  = 1'b1;
    n = 0;
    for (int cyc = 0; cyc < 200 && n < 6; cyc++) begin
      @(negedge I_clk);
      I_maxi_awready = O_maxi_awvalid;
      I_maxi_wready  = 1'b1;
      if (O_maxi_wvalid) n++;
    end
    check("pre_reset_beats", n, 6);
    I_rst          = 1'b1;
    I_ap_start     = 1'b0;
    I_maxi_awready = 1'b0;
    I_maxi_wready  = 1'b0;
    @(negedge I_clk);
    check("midjob_rst_ctl", {O_maxi_awvalid, O_maxi_wvalid, O_maxi_wlast, O_maxi_bready,
                             O_brd, O_ap_done, O_err}, 7'd0);
    check("midjob_rst_addr", {O_maxi_awaddr, O_maxi_awlen, O_braddr}, 74'd0);
    check("midjob_rst_wdata", O_maxi_wdata, 128'd0);
    I_rst = 1'b0;
    run_job(32'h0000_6000, 3, 1, 100, 2, 1'b0, 1'b0);

    // Randomised jobs; the first one wraps the address space
    for (int j = 0; j < 4; j++) begin
      run_job((j == 0) ? 32'hFFFF_FF80 : ($urandom & ~32'hF),
              int'($urandom_range(1, 100)), int'($urandom_range(0, 3)),
              int'($urandom_range(30, 100)), int'($urandom_range(0, 4)),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
